mux10_rr_arbiter: RTL and testbench
===================================

Name: mux10_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 10-way, 16-bit mux10 datapath.
- Ten requesters each present a 16-bit word with a request line.
- The block chooses one requester per accepted transfer and drives the 4-bit select `s` of an internal mux10 instance.
- It registers the selected word into a valid/ready output stage that feeds the downstream consumer.

Parameters:
- DATA_W, 16, word width of each requester and of the output; must match mux10 width.
- NUM_REQ, 10, number of requesters; fixed at 10 to match mux10. Elaboration error if changed.
- SEL_W, 4, select width; must satisfy 2**SEL_W >= NUM_REQ.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  10  req[i] high = requester i has a valid word on d_i.
- d0..d9  input  16 each  requester data words, into mux10 inputs d0..d9.
- gnt  output  10  one-hot grant pulse; gnt[i] high for the cycle in which d_i is captured.
- s  output  4  registered select of the last captured requester; drives mux10 `s` (0..9).
- out_data  output  16  registered selected word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  downstream accepts out_data when out_valid and out_ready are both high.

Behaviour:
- Reset (rst_n low, asynchronous) forces: out_valid=0, out_data=16'h0000, s=4'h0, gnt=0, priority pointer ptr=9.
  - With ptr=9, requester 0 has highest priority after reset.
  - Deasserting reset returns the block to normal operation on the next rising edge.
- Load condition: load = (!out_valid || out_ready) && (req != 0).
- Winner selection (combinational): first set bit of req, scanning ptr+1, ptr+2, ... mod 10.
  - Wraps from 9 to 0.
  - Indices 10..15 never occur.
- Combinational gnt: gnt = load ? onehot(winner) : 0. The grant is the requester's ready; req[i] && gnt[i] is the transfer.
- Datapath: the internal mux10 select is driven combinationally by the winner index during the load cycle, so mux10 output = d_winner.
- On a load edge:
  - out_data <= mux10 output (d_winner);
  - s <= winner;
  - ptr <= winner;
  - out_valid <= 1.
- Latency: req sampled high at edge N → out_valid and out_data valid after edge N, i.e. available in cycle N+1.
- Throughput: one word per cycle while out_ready stays high.
- If out_valid && out_ready && req == 0: out_valid <= 0 at the edge; out_data and s hold their last values.
- Backpressure: if out_valid && !out_ready, then out_data, s, out_valid and ptr all hold, and gnt = 0. No requester is granted; pending req lines stay pending.
- Simultaneous events:
  - Accept and new load in the same cycle → new word replaces the old at that edge with no bubble.
  - Multiple reqs → only the round-robin winner is granted; the others wait.
- Requesters may drop req without a grant; no state is kept for them.
- Fairness: with all 10 reqs held high and out_ready=1, grants cycle 0,1,...,9,0,... Each requester is served once per 10 transfers.
- Mid-operation reset: any in-flight word is discarded. Pointer and outputs return to reset values regardless of req/out_ready.
- gnt is always zero or one-hot; it never asserts for a requester whose req is low.

Decomposition:
- Shared package mux10_pkg holds:
  - constants DATA_W=16, NUM_REQ=10, SEL_W=4;
  - localparam PTR_RESET=4'd9;
  - function rr_pick(req, ptr) returning the winner index and a found flag.
- One sub-module: the existing mux10, instantiated unchanged for the datapath.
- Round-robin logic and the output register stay in mux10_rr_arbiter.

Test Plan:
- Reset then single req: rst_n low 2 cycles, d0..d9 = 000A,000B,000C,000D,0000,000E,000F,0001,0002,0003, req=10'b0000001000, out_ready=1 → gnt[3] pulses one cycle; next cycle out_valid=1, s=3, out_data=000D.
- All requesters, ready high: req=10'h3FF for 12 cycles → s sequence 0,1,2,...,9,0,1 and out_data 000A,000B,000C,000D,0000,000E,... with no idle cycles.
- Backpressure: req=10'h3FF, out_ready=0 after first load (s=0, out_data=000A) for 4 cycles → out_data, s and out_valid hold, gnt=0; on out_ready=1, next s=1 out_data=000B in the same accept edge.
- Wrap and skip: ptr at 8 (last grant 8), req=10'b0000000101 → next grant 0 (9 is not requesting), then 2.
- Drain: req goes to 0 while out_valid=1 and out_ready=1 → out_valid drops next edge; s and out_data retain their last values; gnt stays 0.
- Async reset mid-stream: assert rst_n low between edges while out_valid=1, s=5 → out_valid=0, s=0, out_data=0000 immediately without a clock edge; after release with req=10'h3FF, first grant is 0.

Source files
------------

// File: rtl/mux10_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mux10_pkg
//   Shared constants, types and the round-robin pick helper for the mux10
//   round-robin arbiter slice.
//   Contents:
//     DATA_W      word width of every requester and of the output stage
//     NUM_REQ     number of requesters (fixed at 10 to match mux10)
//     SEL_W       select width for the mux10 instance
//     PTR_RESET   priority pointer after reset (requester 0 wins first)
//     rr_pick_t   winner index plus a found flag
//     rr_pick()   combinational round-robin search
// -----------------------------------------------------------------------------
package mux10_pkg;

  localparam int DATA_W  = 16;
  localparam int NUM_REQ = 10;
  localparam int SEL_W   = 4;

  localparam logic [SEL_W-1:0] PTR_RESET = 4'd9;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } rr_pick_t;

  // Searches ptr+1, ptr+2, ... (mod NUM_REQ) for the first set request.
  // The loop runs from the farthest candidate down to the nearest, so the
  // last hit written is the nearest one after ptr, without needing a break.
  function automatic rr_pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                       input logic [SEL_W-1:0]   ptr);
    rr_pick_t         result;
    int               cand;
    logic [SEL_W-1:0] candIdx;
    result = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand    = (int'(ptr) + k) % NUM_REQ;
      candIdx = SEL_W'(cand);
      if (req[candIdx]) begin
        result.found = 1'b1;
        result.idx   = candIdx;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/mux10_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux10_rr_arbiter_if
//   Bundles the requester side and the valid/ready output side of the
//   arbiter into one interface.
//   Signals:
//     req        [NUM_REQ]  request lines, one per requester
//     d0..d9     [DATA_W]   requester data words
//     gnt        [NUM_REQ]  one-hot grant pulse (combinational)
//     s          [SEL_W]    registered select of the last captured requester
//     out_data   [DATA_W]   registered selected word
//     out_valid             out_data holds an unconsumed word
//     out_ready             downstream accepts out_data this cycle
//   Modports:
//     master  arbiter side (drives gnt, s, out_data, out_valid)
//     slave   requesters + downstream consumer side
// -----------------------------------------------------------------------------
interface mux10_rr_arbiter_if;
  import mux10_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [DATA_W-1:0]  d0, d1, d2, d3, d4, d5, d6, d7, d8, d9;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   s;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic               out_ready;

  modport master (
    input  req, d0, d1, d2, d3, d4, d5, d6, d7, d8, d9, out_ready,
    output gnt, s, out_data, out_valid
  );

  modport slave (
    output req, d0, d1, d2, d3, d4, d5, d6, d7, d8, d9, out_ready,
    input  gnt, s, out_data, out_valid
  );

endinterface

// File: rtl/mux10_rr_arbiter_mux10.sv
// -----------------------------------------------------------------------------
// mux10
//   Plain combinational 10-way word multiplexer used as the shared datapath.
//   Ports:
//     d0..d9  [DATA_W]  input words
//     s       [SEL_W]   select, 0..9; codes 10..15 produce zero
//     y       [DATA_W]  selected word
// -----------------------------------------------------------------------------
module mux10 #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 4
) (
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  input  logic [DATA_W-1:0] d4,
  input  logic [DATA_W-1:0] d5,
  input  logic [DATA_W-1:0] d6,
  input  logic [DATA_W-1:0] d7,
  input  logic [DATA_W-1:0] d8,
  input  logic [DATA_W-1:0] d9,
  input  logic [SEL_W-1:0]  s,
  output logic [DATA_W-1:0] y
);

  // Unused select codes fall through to zero so the output is never a latch.
  always_comb begin
    y = '0;
    case (s)
      SEL_W'(0): y = d0;
      SEL_W'(1): y = d1;
      SEL_W'(2): y = d2;
      SEL_W'(3): y = d3;
      SEL_W'(4): y = d4;
      SEL_W'(5): y = d5;
      SEL_W'(6): y = d6;
      SEL_W'(7): y = d7;
      SEL_W'(8): y = d8;
      SEL_W'(9): y = d9;
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/mux10_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux10_rr_arbiter
//   Round-robin arbiter and sequencer in front of the shared mux10 datapath.
//   Picks one requester per accepted transfer, steers mux10 to it, and
//   registers the chosen word into a valid/ready output stage.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    mux10_rr_arbiter_if.master (requests, data, grant, output stage)
// -----------------------------------------------------------------------------
module mux10_rr_arbiter
  import mux10_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  mux10_rr_arbiter_if.master  bus
);

  // The datapath is hard-wired to a 10-input mux; refuse other sizes.
  if (NUM_REQ != 10) begin : gNumReqCheck
    $error("mux10_rr_arbiter: NUM_REQ must be 10");
  end
  if ((1 << SEL_W) < NUM_REQ) begin : gSelWCheck
    $error("mux10_rr_arbiter: SEL_W too narrow for NUM_REQ");
  end

  logic [SEL_W-1:0]  ptr_q,       ptr_d;
  logic [SEL_W-1:0]  s_q,         s_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_valid_q, out_valid_d;

  rr_pick_t          pick;
  logic              load;
  logic [DATA_W-1:0] muxOut;

  // Winner search and load decision. The output stage can take a new word
  // when it is empty or being drained this cycle. Gating with rst_n keeps
  // the grant quiet while reset is held.
  always_comb begin
    pick = rr_pick(bus.req, ptr_q);
    load = rst_n && (!out_valid_q || bus.out_ready) && pick.found;
  end

  assign bus.gnt = load ? (NUM_REQ'(1) << pick.idx) : '0;

  // mux10 follows the winner combinationally so its output is d_winner on
  // the load edge.
  mux10 #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) uMux10 (
    .d0 (bus.d0),
    .d1 (bus.d1),
    .d2 (bus.d2),
    .d3 (bus.d3),
    .d4 (bus.d4),
    .d5 (bus.d5),
    .d6 (bus.d6),
    .d7 (bus.d7),
    .d8 (bus.d8),
    .d9 (bus.d9),
    .s  (pick.idx),
    .y  (muxOut)
  );

  // Next-state for the output stage. A load replaces the held word even if
  // it is being accepted in the same cycle, so there is no bubble. Without
  // a load, an accepted word simply empties the stage; under backpressure
  // everything holds.
  always_comb begin
    ptr_d       = ptr_q;
    s_d         = s_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_data_d  = muxOut;
      s_d         = pick.idx;
      ptr_d       = pick.idx;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= PTR_RESET;
      s_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      s_q         <= s_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.s         = s_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux10_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux10_rr_arbiter
//   Directed self-checking bench for mux10_rr_arbiter. Inputs change 1 ns
//   after a rising edge; the combinational grant is checked on the falling
//   edge and registered outputs 1 ns after the following rising edge.
// -----------------------------------------------------------------------------
module tb_mux10_rr_arbiter;

  localparam logic [15:0] DV [10] = '{16'h000A, 16'h000B, 16'h000C, 16'h000D,
                                      16'h0000, 16'h000E, 16'h000F, 16'h0001,
                                      16'h0002, 16'h0003};

  logic clk;
  logic rst_n;
  int   checkCount;
  int   failCount;

  mux10_rr_arbiter_if bus ();

  mux10_rr_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.d0 = DV[0];
  assign bus.d1 = DV[1];
  assign bus.d2 = DV[2];
  assign bus.d3 = DV[3];
  assign bus.d4 = DV[4];
  assign bus.d5 = DV[5];
  assign bus.d6 = DV[6];
  assign bus.d7 = DV[7];
  assign bus.d8 = DV[8];
  assign bus.d9 = DV[9];

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives the request lines and downstream ready.
  task automatic applyStimulus(input logic [9:0] reqVal, input logic readyVal);
    bus.req       = reqVal;
    bus.out_ready = readyVal;
  endtask

  // One clock: grant before the edge, output stage after it.
  task automatic cycleCheck(input string tag, input logic [9:0] expGnt,
                            input logic expValid, input logic [3:0] expS,
                            input logic [15:0] expData);
    @(negedge clk);
    checkOutput({tag, ".gnt"}, 32'(bus.gnt), 32'(expGnt));
    @(posedge clk);
    #1;
    checkOutput({tag, ".valid"}, 32'(bus.out_valid), 32'(expValid));
    checkOutput({tag, ".s"},     32'(bus.s),         32'(expS));
    checkOutput({tag, ".data"},  32'(bus.out_data),  32'(expData));
  endtask

  // Holds reset for two edges, checks reset values, then releases.
  task automatic doReset(input string tag);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, ".s"},     32'(bus.s),         32'd0);
    checkOutput({tag, ".data"},  32'(bus.out_data),  32'd0);
    checkOutput({tag, ".gnt"},   32'(bus.gnt),       32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    rst_n      = 1'b0;
    applyStimulus(10'h000, 1'b1);

    // Reset, then a single request from requester 3
    doReset("rst0");
    applyStimulus(10'b0000001000, 1'b1);
    cycleCheck("single", 10'h008, 1'b1, 4'd3, 16'h000D);
    applyStimulus(10'h000, 1'b1);
    cycleCheck("single.drop", 10'h000, 1'b0, 4'd3, 16'h000D);

    // All requesters, ready high: strict rotation starting at 0
    doReset("rst1");
    applyStimulus(10'h3FF, 1'b1);
    for (int k = 0; k < 12; k++) begin
      cycleCheck($sformatf("all%0d", k), 10'(1 << (k % 10)), 1'b1,
                 4'(k % 10), DV[k % 10]);
    end

    // Backpressure after the first load
    doReset("rst2");
    applyStimulus(10'h3FF, 1'b1);
    cycleCheck("bp.first", 10'h001, 1'b1, 4'd0, 16'h000A);
    applyStimulus(10'h3FF, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycleCheck($sformatf("bp.hold%0d", k), 10'h000, 1'b1, 4'd0, 16'h000A);
    end
    applyStimulus(10'h3FF, 1'b1);
    cycleCheck("bp.release", 10'h002, 1'b1, 4'd1, 16'h000B);

    // Wrap and skip: last grant 8, requesters 0 and 2 pending
    applyStimulus(10'h100, 1'b1);
    cycleCheck("wrap.setup", 10'h100, 1'b1, 4'd8, 16'h0002);
    applyStimulus(10'b0000000101, 1'b1);
    cycleCheck("wrap0", 10'h001, 1'b1, 4'd0, 16'h000A);
    cycleCheck("wrap2", 10'h004, 1'b1, 4'd2, 16'h000C);

    // Drain: no requests, stage empties, select and data hold
    applyStimulus(10'h000, 1'b1);
    cycleCheck("drain", 10'h000, 1'b0, 4'd2, 16'h000C);
    cycleCheck("drain.idle", 10'h000, 1'b0, 4'd2, 16'h000C);

    // Asynchronous reset between edges with a word in flight at s=5
    applyStimulus(10'h020, 1'b1);
    cycleCheck("pre.rst", 10'h020, 1'b1, 4'd5, 16'h000E);
    applyStimulus(10'h3FF, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async.valid", 32'(bus.out_valid), 32'd0);
    checkOutput("async.s",     32'(bus.s),         32'd0);
    checkOutput("async.data",  32'(bus.out_data),  32'd0);
    checkOutput("async.gnt",   32'(bus.gnt),       32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycleCheck("post.rst", 10'h001, 1'b1, 4'd0, 16'h000A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, failCount);
    $finish;
  end

endmodule
